// File: rtl/collatz_pkg.sv
// Shared types for the Collatz engine: FSM states and error codes.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ZERO = 2'b01;
    localparam logic [1:0] ERR_VOVF = 2'b10;
    localparam logic [1:0] ERR_SOVF = 2'b11;

endpackage

// File: rtl/collatz_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector; one pulse per edge,
// asserted during the cycle after the synchronised level first rises.
module collatz_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/collatz_engine.sv
// Collatz iterator: byte-serial load, one 3n+1 or n/2 step per clock.
// Strobes are edge-triggered pins (sync + edge detect); there is no backpressure.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEPW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               load_in,
    input  logic               start_in,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic [STEPW-1:0]   steps,
    output logic [WIDTH+1:0]   peak
);

    logic ld_p, st_p;

    collatz_sync_edge u_ld_sync (.clk(clk), .reset(reset), .async_i(load_in),  .pulse_o(ld_p));
    collatz_sync_edge u_st_sync (.clk(clk), .reset(reset), .async_i(start_in), .pulse_o(st_p));

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH+1:0]   n_q, n_d;
    logic [STEPW-1:0]   steps_q, steps_d;
    logic [WIDTH+1:0]   peak_q, peak_d;
    logic [1:0]         err_q, err_d;

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH+2:0]   t;

    generate
        if (WIDTH == 8) begin : g_w8
            assign shifted = data_in;
        end else begin : g_wn
            assign shifted = {value_q[WIDTH-9:0], data_in};
        end
    endgenerate

    // One extra bit beyond n so the overflow of 3n+1 is visible in t's MSB.
    assign t = {n_q, 1'b0} + {1'b0, n_q} + {{(WIDTH+2){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        n_d     = n_q;
        steps_d = steps_q;
        peak_d  = peak_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                // Start has priority; a coincident load byte is dropped.
                if (st_p) begin
                    steps_d = '0;
                    if (value_q == '0) begin
                        state_d = DONE;
                        err_d   = ERR_ZERO;
                        peak_d  = '0;
                    end else begin
                        state_d = RUN;
                        err_d   = ERR_NONE;
                        n_d     = {2'b00, value_q};
                        peak_d  = {2'b00, value_q};
                    end
                end else if (ld_p) begin
                    value_d = shifted;
                    if (state_q == DONE) begin
                        state_d = IDLE;
                        err_d   = ERR_NONE;
                        steps_d = '0;
                        peak_d  = '0;
                    end
                end
            end
            RUN: begin
                if (n_q == {{(WIDTH+1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end else if (steps_q == '1) begin
                    state_d = DONE;
                    err_d   = ERR_SOVF;
                end else if (!n_q[0]) begin
                    n_d     = n_q >> 1;
                    steps_d = steps_q + {{(STEPW-1){1'b0}}, 1'b1};
                end else if (t[WIDTH+2]) begin
                    state_d = DONE;
                    err_d   = ERR_VOVF;
                end else begin
                    n_d     = t[WIDTH+1:0];
                    steps_d = steps_q + {{(STEPW-1){1'b0}}, 1'b1};
                    if (t[WIDTH+1:0] > peak_q) begin
                        peak_d = t[WIDTH+1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            value_q <= '0;
            n_q     <= '0;
            steps_q <= '0;
            peak_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            n_q     <= n_d;
            steps_q <= steps_d;
            peak_q  <= peak_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign steps = steps_q;
    assign peak  = peak_q;

endmodule
